// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter (round-robin or fixed priority) in front of one shared line memory.
// Define MEM_ARB_PERF_CNT_EN to add per-port grant and stall counters.
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 256,
    parameter int ARB_MODE  = 0
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_PORTS-1:0]           ch_req_i,
    input  logic [NUM_PORTS-1:0]           ch_write_i,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0] ch_addr_i,
    input  logic [NUM_PORTS*LINE_SIZE-1:0] ch_wdata_i,
    output logic [NUM_PORTS-1:0]           ch_done_o,
    output logic [LINE_SIZE-1:0]           ch_rdata_o,
    output logic [NUM_PORTS-1:0]           grant_o,
    output logic                           mem_valid_o,
    output logic                           mem_write_o,
    output logic [ADDR_SIZE-1:0]           mem_addr_o,
    output logic [LINE_SIZE-1:0]           mem_wdata_o,
    input  logic                           mem_ready_i,
    input  logic                           mem_done_i,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [NUM_PORTS*32-1:0]        perf_grant_cnt_o,
    output logic [NUM_PORTS*32-1:0]        perf_stall_cnt_o,
`endif
    input  logic [LINE_SIZE-1:0]           mem_rdata_i
);

    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]        gidx_q, gidx_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   abort_q, abort_d;

    logic                   win_found;
    logic [ID_W-1:0]        win_idx;
    logic [NUM_PORTS-1:0]   win_oh;
    logic                   done_fire;
    int                     cand;

    // Round-robin scans from ptr+1 with wrap; fixed mode scans from index 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        cand      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ARB_MODE == 1) begin
                cand = i;
            end else begin
                cand = int'(ptr_q) + 1 + i;
                if (cand >= NUM_PORTS) begin
                    cand = cand - NUM_PORTS;
                end
            end
            if (!win_found && ch_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        mem_valid_d = mem_valid_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        abort_d     = abort_q;
        done_fire   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d     = S_REQ;
                    grant_d     = win_oh;
                    gidx_d      = win_idx;
                    mem_valid_d = 1'b1;
                    mem_write_d = ch_write_i[win_idx];
                    mem_addr_d  = ch_addr_i[int'(win_idx)*ADDR_SIZE +: ADDR_SIZE];
                    mem_wdata_d = ch_wdata_i[int'(win_idx)*LINE_SIZE +: LINE_SIZE];
                    abort_d     = 1'b0;
                end
            end
            S_REQ: begin
                if (mem_ready_i) begin
                    mem_valid_d = 1'b0;
                    if (mem_done_i) begin
                        done_fire = 1'b1;
                        state_d   = S_IDLE;
                        grant_d   = '0;
                        ptr_d     = gidx_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_done_i) begin
                    done_fire = 1'b1;
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    ptr_d     = gidx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= ID_W'(NUM_PORTS - 1);
            mem_valid_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            abort_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            mem_valid_q <= mem_valid_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            abort_q     <= abort_d;
        end
    end

    assign grant_o     = grant_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign ch_done_o   = grant_q & {NUM_PORTS{done_fire}};
    assign ch_rdata_o  = mem_rdata_i;

`ifdef MEM_ARB_PERF_CNT_EN
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_perf
        logic [31:0] gcnt_q;
        logic [31:0] scnt_q;
        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                gcnt_q <= '0;
                scnt_q <= '0;
            end else begin
                if (ch_done_o[k] && (gcnt_q != 32'hFFFF_FFFF)) begin
                    gcnt_q <= gcnt_q + 32'd1;
                end
                if (ch_req_i[k] && !grant_q[k] && (scnt_q != 32'hFFFF_FFFF)) begin
                    scnt_q <= scnt_q + 32'd1;
                end
            end
        end
        assign perf_grant_cnt_o[k*32 +: 32] = gcnt_q;
        assign perf_stall_cnt_o[k*32 +: 32] = scnt_q;
    end
`endif

    // A done after reset but before the next grant belongs to an aborted transaction.
    a_hold_req: assert property (@(posedge clk_i) disable iff (!reset_i)
        (state_q != S_IDLE) |-> ((ch_req_i & grant_q) == grant_q));

    a_stray_done: assert property (@(posedge clk_i) disable iff (!reset_i)
        (mem_done_i && !abort_q) |->
        ((state_q == S_WAIT) || ((state_q == S_REQ) && mem_ready_i)));

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed scoreboard bench for mem_arbiter_rr: 2-port RR, 4-port RR and 4-port fixed priority.
// Perf counter step is built only with MEM_ARB_PERF_CNT_EN.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]   req2, wr2, cdone2, gnt2;
    logic [63:0]  a2;
    logic [511:0] wd2;
    logic [255:0] rd2, crd2, mwd2;
    logic [31:0]  ma2;
    logic         rdy2, mdone2, mv2, mw2;

    logic [3:0]   req4, wr4, cdone4, gnt4, cdone4p, gnt4p;
    logic [127:0] a4, wd4;
    logic [31:0]  rd4, crd4, crd4p, ma4, ma4p, mwd4, mwd4p;
    logic         rdy4, mdone4, mv4, mw4, mv4p, mw4p;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [63:0]  pg2, ps2;
    logic [127:0] pg4, ps4, pg4p, ps4p;
`endif

    mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_SIZE(32), .LINE_SIZE(256), .ARB_MODE(0)) u2 (
        .clk_i(clk), .reset_i(rst_n), .ch_req_i(req2), .ch_write_i(wr2),
        .ch_addr_i(a2), .ch_wdata_i(wd2), .ch_done_o(cdone2), .ch_rdata_o(crd2),
        .grant_o(gnt2), .mem_valid_o(mv2), .mem_write_o(mw2), .mem_addr_o(ma2),
        .mem_wdata_o(mwd2), .mem_ready_i(rdy2), .mem_done_i(mdone2),
`ifdef MEM_ARB_PERF_CNT_EN
        .perf_grant_cnt_o(pg2), .perf_stall_cnt_o(ps2),
`endif
        .mem_rdata_i(rd2));

    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_SIZE(32), .LINE_SIZE(32), .ARB_MODE(0)) u4 (
        .clk_i(clk), .reset_i(rst_n), .ch_req_i(req4), .ch_write_i(wr4),
        .ch_addr_i(a4), .ch_wdata_i(wd4), .ch_done_o(cdone4), .ch_rdata_o(crd4),
        .grant_o(gnt4), .mem_valid_o(mv4), .mem_write_o(mw4), .mem_addr_o(ma4),
        .mem_wdata_o(mwd4), .mem_ready_i(rdy4), .mem_done_i(mdone4),
`ifdef MEM_ARB_PERF_CNT_EN
        .perf_grant_cnt_o(pg4), .perf_stall_cnt_o(ps4),
`endif
        .mem_rdata_i(rd4));

    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_SIZE(32), .LINE_SIZE(32), .ARB_MODE(1)) u4p (
        .clk_i(clk), .reset_i(rst_n), .ch_req_i(req4), .ch_write_i(wr4),
        .ch_addr_i(a4), .ch_wdata_i(wd4), .ch_done_o(cdone4p), .ch_rdata_o(crd4p),
        .grant_o(gnt4p), .mem_valid_o(mv4p), .mem_write_o(mw4p), .mem_addr_o(ma4p),
        .mem_wdata_o(mwd4p), .mem_ready_i(rdy4), .mem_done_i(mdone4),
`ifdef MEM_ARB_PERF_CNT_EN
        .perf_grant_cnt_o(pg4p), .perf_stall_cnt_o(ps4p),
`endif
        .mem_rdata_i(rd4));

    int n_cmp = 0;
    int n_bad = 0;
    int exp2[$];
    int exp4[$];
    int exp4p[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req2 = '0; wr2 = '0; rdy2 = 1'b0; mdone2 = 1'b0;
        req4 = '0; rdy4 = 1'b0; mdone4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic xact2(input string tag);
        int p;
        int k;
        k = 0;
        while (mv2 !== 1'b1 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk({tag, "_valid"}, 256'(mv2), 256'(1));
        p = exp2.pop_front();
        chk({tag, "_gnt"}, 256'(gnt2), 256'(1) << p);
        chk({tag, "_addr"}, 256'(ma2), 256'(32'h100 * (p + 1)));
        rdy2 = 1'b1; mdone2 = 1'b1; rd2 = {8{$urandom()}};
        #1;
        chk({tag, "_done"}, 256'(cdone2), 256'(1) << p);
        chk({tag, "_rdata"}, crd2, rd2);
        @(negedge clk);
        rdy2 = 1'b0; mdone2 = 1'b0;
        #1;
    endtask

    task automatic xact4(input string tag);
        int p;
        int q;
        int k;
        k = 0;
        while (mv4 !== 1'b1 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk({tag, "_valid"}, 256'(mv4), 256'(1));
        chk({tag, "_valid_fp"}, 256'(mv4p), 256'(1));
        p = exp4.pop_front();
        q = exp4p.pop_front();
        chk({tag, "_gnt"}, 256'(gnt4), 256'(1) << p);
        chk({tag, "_gnt_fp"}, 256'(gnt4p), 256'(1) << q);
        chk({tag, "_addr"}, 256'(ma4), 256'(32'h4000 + p));
        chk({tag, "_wr"}, 256'(mw4), 256'(wr4[p]));
        chk({tag, "_wdata"}, 256'(mwd4), 256'(32'hD000_0000 + p));
        chk({tag, "_addr_fp"}, 256'(ma4p), 256'(32'h4000 + q));
        rdy4 = 1'b1; mdone4 = 1'b1; rd4 = $urandom();
        #1;
        chk({tag, "_done"}, 256'(cdone4), 256'(1) << p);
        chk({tag, "_done_fp"}, 256'(cdone4p), 256'(1) << q);
        chk({tag, "_rdata"}, 256'(crd4), 256'(rd4));
        @(negedge clk);
        rdy4 = 1'b0; mdone4 = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        req2 = '0; wr2 = '0; rdy2 = 1'b0; mdone2 = 1'b0; rd2 = '0;
        a2 = {32'h200, 32'h100};
        wd2 = {256'hBEEF, 256'hCAFE};
        req4 = '0; rdy4 = 1'b0; mdone4 = 1'b0; rd4 = '0;
        wr4 = 4'b1010;
        a4 = {32'h4003, 32'h4002, 32'h4001, 32'h4000};
        wd4 = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt", 256'(gnt2), 256'(0));
        chk("rst_valid", 256'(mv2), 256'(0));
        chk("rst_done", 256'(cdone2), 256'(0));
        chk("rst_addr", 256'(ma2), 256'(0));
        chk("rst_wr", 256'(mw2), 256'(0));
        chk("rst_gnt4", 256'(gnt4), 256'(0));

        // step 1: single read from port 0
        rst_n = 1'b1;
        req2 = 2'b01;
        exp2.push_back(0);
        @(negedge clk); #1;
        chk("t1_valid", 256'(mv2), 256'(1));
        chk("t1_addr", 256'(ma2), 256'(32'h100));
        chk("t1_wr", 256'(mw2), 256'(0));
        chk("t1_gnt", 256'(gnt2), 256'(2'b01));
        @(negedge clk);
        rdy2 = 1'b1;
        @(negedge clk);
        rdy2 = 1'b0;
        #1;
        chk("t1_wait_valid", 256'(mv2), 256'(0));
        chk("t1_wait_done", 256'(cdone2), 256'(0));
        @(negedge clk);
        mdone2 = 1'b1;
        rd2 = {32{8'hA5}};
        #1;
        chk("t1_done", 256'(cdone2), 256'(1) << exp2.pop_front());
        chk("t1_rdata", crd2, {32{8'hA5}});
        @(negedge clk);
        mdone2 = 1'b0;
        req2 = 2'b00;
        #1;
        chk("t1_idle_gnt", 256'(gnt2), 256'(0));
        chk("t1_idle_done", 256'(cdone2), 256'(0));

        // step 2: both ports continuously -> 0,1,0,1
        do_reset();
        req2 = 2'b11;
        exp2.push_back(0); exp2.push_back(1);
        exp2.push_back(0); exp2.push_back(1);
        for (int i = 0; i < 4; i++) xact2("t2");
        req2 = 2'b00;

        // step 3: move pointer to 2, then ports 0,2,3 -> 3,0,2,3 (fixed: 0s)
        do_reset();
        req4 = 4'b0100;
        exp4.push_back(2);
        exp4p.push_back(2);
        xact4("t3_setup");
        req4 = 4'b1101;
        exp4.push_back(3); exp4.push_back(0);
        exp4.push_back(2); exp4.push_back(3);
        for (int i = 0; i < 4; i++) exp4p.push_back(0);
        for (int i = 0; i < 4; i++) xact4("t3");

        // step 4: ports 1,3 -> fixed always 1, rr alternates 1,3
        req4 = 4'b1010;
        exp4.push_back(1); exp4.push_back(3);
        exp4.push_back(1); exp4.push_back(3);
        for (int i = 0; i < 4; i++) exp4p.push_back(1);
        for (int i = 0; i < 4; i++) xact4("t4");
        req4 = 4'b0000;

        // step 5: reset while in WAIT, then a late done
        do_reset();
        req2 = 2'b10;
        k = 0;
        while (mv2 !== 1'b1 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk("t5_valid", 256'(mv2), 256'(1));
        chk("t5_gnt", 256'(gnt2), 256'(2'b10));
        rdy2 = 1'b1;
        @(negedge clk);
        rdy2 = 1'b0;
        #1;
        chk("t5_wait", 256'(mv2), 256'(0));
        rst_n = 1'b0;
        req2 = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        mdone2 = 1'b1;
        #1;
        chk("t5_done", 256'(cdone2), 256'(0));
        chk("t5_gnt0", 256'(gnt2), 256'(0));
        chk("t5_valid0", 256'(mv2), 256'(0));
        chk("t5_addr0", 256'(ma2), 256'(0));
        @(negedge clk);
        mdone2 = 1'b0;
        #1;
        chk("t5_gnt1", 256'(gnt2), 256'(0));
        chk("t5_valid1", 256'(mv2), 256'(0));
        chk("t5_done1", 256'(cdone2), 256'(0));

`ifdef MEM_ARB_PERF_CNT_EN
        // step 6: port 1 stalls 7 cycles behind port 0
        do_reset();
        req2 = 2'b11;
        @(negedge clk);
        rdy2 = 1'b1;
        @(negedge clk);
        rdy2 = 1'b0;
        repeat (3) @(negedge clk);
        mdone2 = 1'b1;
        #1;
        chk("t6_done0", 256'(cdone2), 256'(2'b01));
        @(negedge clk);
        mdone2 = 1'b0;
        req2 = 2'b10;
        @(negedge clk);
        rdy2 = 1'b1;
        mdone2 = 1'b1;
        #1;
        chk("t6_done1", 256'(cdone2), 256'(2'b10));
        @(negedge clk);
        rdy2 = 1'b0;
        mdone2 = 1'b0;
        req2 = 2'b00;
        #1;
        chk("t6_stall1", 256'(ps2[63:32]), 256'(7));
        chk("t6_stall0", 256'(ps2[31:0]), 256'(1));
        chk("t6_grant1", 256'(pg2[63:32]), 256'(1));
        chk("t6_grant0", 256'(pg2[31:0]), 256'(1));
`endif

        chk("sb_empty2", 256'(exp2.size()), 256'(0));
        chk("sb_empty4", 256'(exp4.size() + exp4p.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
